// File: rtl/game_control_multi.sv
// Multi-player light-cycle game controller: owns the tile map, moves players on each step and
// resolves crashes, draws and winners. Define WRAP_EN for a frameless map with wrap-around edges.
package game_pkg;
    localparam int MAP_WIDTH  = 16;
    localparam int MAP_HEIGHT = 12;
    typedef enum logic [2:0] {EMPTY, FRAME, PLAYER1, PLAYER2, PLAYER3, PLAYER4} tile;
    typedef enum logic [2:0] {WAIT, RIGHT, LEFT, DOWN, UP} directions;
endpackage

module game_control_multi
    import game_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int MAP_W     = MAP_WIDTH,
    parameter int MAP_H     = MAP_HEIGHT,
    parameter int COORD_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  directions            direction [N_PLAYERS],
    output tile                  map [MAP_W][MAP_H],
    output logic [N_PLAYERS-1:0] collision,
    output logic [N_PLAYERS-1:0] alive,
    output logic                 game_over,
    output logic                 draw,
    output logic [1:0]           winner
);

`ifdef WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] START_Y = COORD_W'(MAP_H / 2);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t               state, state_next;
    logic [COORD_W-1:0]   head_x [N_PLAYERS];
    logic [COORD_W-1:0]   head_y [N_PLAYERS];
    directions            last_move [N_PLAYERS];

    logic                 do_step, reinit;
    logic [COORD_W-1:0]   tgt_x [N_PLAYERS];
    logic [COORD_W-1:0]   tgt_y [N_PLAYERS];
    tile                  tgt_tile [N_PLAYERS];
    logic [N_PLAYERS-1:0] moving, crash, alive_next;
    int                   alive_cnt;
    logic                 over_next, draw_next;
    logic [1:0]           winner_next;

    function automatic logic [COORD_W-1:0] start_x(int k);
        return COORD_W'((k + 1) * MAP_W / (N_PLAYERS + 1));
    endfunction

    function automatic tile init_tile(int x, int y);
        tile t;
        t = EMPTY;
        if (!WRAP && (x == 0 || x == MAP_W - 1 || y == 0 || y == MAP_H - 1))
            t = FRAME;
        for (int k = 0; k < N_PLAYERS; k++)
            if (COORD_W'(x) == start_x(k) && COORD_W'(y) == START_Y)
                t = tile'(3'(PLAYER1) + 3'(k));
        return t;
    endfunction

    function automatic logic [COORD_W-1:0] coord_inc(logic [COORD_W-1:0] v, int lim);
        return (WRAP && v == COORD_W'(lim - 1)) ? '0 : v + ONE;
    endfunction

    function automatic logic [COORD_W-1:0] coord_dec(logic [COORD_W-1:0] v, int lim);
        return (WRAP && v == '0) ? COORD_W'(lim - 1) : v - ONE;
    endfunction

    function automatic directions opposite(directions d);
        case (d)
            RIGHT:   return LEFT;
            LEFT:    return RIGHT;
            DOWN:    return UP;
            UP:      return DOWN;
            default: return WAIT;
        endcase
    endfunction

    // Every alive player is judged against the pre-step map; shared targets crash all contenders.
    always_comb begin
        do_step = (state == RUN) && step;
        reinit  = (state == OVER) && start;
        moving  = '0;
        crash   = '0;
        for (int k = 0; k < N_PLAYERS; k++) begin
            tgt_x[k]    = head_x[k];
            tgt_y[k]    = head_y[k];
            tgt_tile[k] = EMPTY;
            if (do_step && alive[k] && direction[k] != WAIT && direction[k] != opposite(last_move[k])) begin
                moving[k] = 1'b1;
                case (direction[k])
                    RIGHT:   tgt_x[k] = coord_inc(head_x[k], MAP_W);
                    LEFT:    tgt_x[k] = coord_dec(head_x[k], MAP_W);
                    DOWN:    tgt_y[k] = coord_inc(head_y[k], MAP_H);
                    UP:      tgt_y[k] = coord_dec(head_y[k], MAP_H);
                    default: ;
                endcase
            end
            for (int x = 0; x < MAP_W; x++)
                for (int y = 0; y < MAP_H; y++)
                    if (tgt_x[k] == COORD_W'(x) && tgt_y[k] == COORD_W'(y))
                        tgt_tile[k] = map[x][y];
        end
        for (int k = 0; k < N_PLAYERS; k++) begin
            if (moving[k] && tgt_tile[k] != EMPTY)
                crash[k] = 1'b1;
            for (int j = 0; j < N_PLAYERS; j++)
                if (j != k && moving[k] && moving[j] && tgt_x[k] == tgt_x[j] && tgt_y[k] == tgt_y[j])
                    crash[k] = 1'b1;
        end
        alive_next  = alive & ~crash;
        alive_cnt   = 0;
        winner_next = '0;
        for (int k = 0; k < N_PLAYERS; k++)
            if (alive_next[k]) begin
                alive_cnt   = alive_cnt + 1;
                winner_next = 2'(k);
            end
        if (N_PLAYERS > 1)
            over_next = do_step && (alive_cnt <= 1);
        else
            over_next = do_step && (alive_cnt == 0);
        draw_next = (alive_cnt == 0);

        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (over_next) state_next = OVER;
            OVER:    if (start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Re-arming from OVER rebuilds the map exactly as reset does.
    always_ff @(posedge clk) begin
        if (rst || reinit) begin
            for (int x = 0; x < MAP_W; x++)
                for (int y = 0; y < MAP_H; y++)
                    map[x][y] <= init_tile(x, y);
            for (int k = 0; k < N_PLAYERS; k++) begin
                head_x[k]    <= start_x(k);
                head_y[k]    <= START_Y;
                last_move[k] <= WAIT;
            end
            collision <= '0;
            alive     <= '1;
            game_over <= 1'b0;
            draw      <= 1'b0;
            winner    <= '0;
        end else if (do_step) begin
            for (int k = 0; k < N_PLAYERS; k++)
                if (moving[k] && !crash[k]) begin
                    head_x[k]    <= tgt_x[k];
                    head_y[k]    <= tgt_y[k];
                    last_move[k] <= direction[k];
                end
            for (int x = 0; x < MAP_W; x++)
                for (int y = 0; y < MAP_H; y++)
                    for (int k = 0; k < N_PLAYERS; k++)
                        if (moving[k] && !crash[k] && tgt_x[k] == COORD_W'(x) && tgt_y[k] == COORD_W'(y))
                            map[x][y] <= tile'(3'(PLAYER1) + 3'(k));
            collision <= collision | crash;
            alive     <= alive_next;
            game_over <= over_next;
            draw      <= over_next && draw_next;
            winner    <= over_next ? winner_next : '0;
        end
    end

endmodule

// File: tb/tb_game_control_multi.sv
// Self-checking bench for game_control_multi: a coordinate-level game model compared every cycle,
// plus directed scenarios with literal expectations. Honours WRAP_EN like the design.
module tb_game_control_multi;
    import game_pkg::*;

    localparam int NP = 2;
    localparam int W  = 16;
    localparam int H  = 12;
`ifdef WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, step;
    directions     dir [NP];
    tile           dmap [W][H];
    logic [NP-1:0] collision, alive;
    logic          game_over, draw;
    logic [1:0]    winner;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // model: 0 empty, 1 frame, 2+k player k
    int mm [W][H];
    int px [NP];
    int py [NP];
    int lastd [NP];
    bit malive [NP];
    bit mcoll [NP];
    int mstate;
    bit mover, mdraw;
    int mwin;

    game_control_multi #(.N_PLAYERS(NP), .MAP_W(W), .MAP_H(H), .COORD_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .direction(dir),
        .map(dmap), .collision(collision), .alive(alive), .game_over(game_over),
        .draw(draw), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic int dxOf(int d);
        return (d == 1) ? 1 : (d == 2) ? -1 : 0;
    endfunction

    function automatic int dyOf(int d);
        return (d == 3) ? 1 : (d == 4) ? -1 : 0;
    endfunction

    task automatic modelInit();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                mm[x][y] = (!WRAP && (x == 0 || x == W - 1 || y == 0 || y == H - 1)) ? 1 : 0;
        for (int k = 0; k < NP; k++) begin
            px[k] = (k + 1) * W / (NP + 1);
            py[k] = H / 2;
            mm[px[k]][py[k]] = 2 + k;
            lastd[k] = 0;
            malive[k] = 1'b1;
            mcoll[k] = 1'b0;
        end
        mstate = 0;
        mover = 1'b0;
        mdraw = 1'b0;
        mwin = 0;
    endtask

    task automatic modelClock(bit r, bit s, bit st, directions d0, directions d1);
        int d [NP];
        int tx [NP];
        int ty [NP];
        bit mv [NP];
        bit cr [NP];
        int cnt;
        d[0] = int'(d0);
        d[1] = int'(d1);
        if (r) begin
            modelInit();
            return;
        end
        if (mstate == 0) begin
            if (s) mstate = 1;
        end else if (mstate == 2) begin
            if (s) modelInit();
        end else if (st) begin
            for (int k = 0; k < NP; k++) begin
                mv[k] = 1'b0;
                cr[k] = 1'b0;
                tx[k] = px[k];
                ty[k] = py[k];
                if (malive[k] && d[k] != 0 &&
                    !(lastd[k] != 0 && dxOf(d[k]) == -dxOf(lastd[k]) && dyOf(d[k]) == -dyOf(lastd[k]))) begin
                    mv[k] = 1'b1;
                    tx[k] = px[k] + dxOf(d[k]);
                    ty[k] = py[k] + dyOf(d[k]);
                    if (WRAP) begin
                        tx[k] = (tx[k] + W) % W;
                        ty[k] = (ty[k] + H) % H;
                    end
                end
            end
            for (int k = 0; k < NP; k++) begin
                if (mv[k]) begin
                    if (tx[k] < 0 || tx[k] >= W || ty[k] < 0 || ty[k] >= H) cr[k] = 1'b1;
                    else if (mm[tx[k]][ty[k]] != 0) cr[k] = 1'b1;
                    for (int j = 0; j < NP; j++)
                        if (j != k && mv[j] && tx[j] == tx[k] && ty[j] == ty[k]) cr[k] = 1'b1;
                end
            end
            cnt = 0;
            for (int k = 0; k < NP; k++) begin
                if (mv[k] && !cr[k]) begin
                    mm[tx[k]][ty[k]] = 2 + k;
                    px[k] = tx[k];
                    py[k] = ty[k];
                    lastd[k] = d[k];
                end
                if (cr[k]) begin
                    malive[k] = 1'b0;
                    mcoll[k] = 1'b1;
                end
                if (malive[k]) begin
                    cnt++;
                    mwin = k;
                end
            end
            if (cnt <= 1) begin
                mover = 1'b1;
                mdraw = (cnt == 0);
                mstate = 2;
            end
        end
    endtask

    task automatic expectEq(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkOutput();
        int bad, bx, by, cv, av;
        bad = 0; bx = 0; by = 0; cv = 0; av = 0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                if (int'(dmap[x][y]) != mm[x][y]) begin
                    if (bad == 0) begin bx = x; by = y; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL map: %0d tiles differ, first (%0d,%0d) got %0d expected %0d",
                     bad, bx, by, int'(dmap[bx][by]), mm[bx][by]);
        end
        for (int k = 0; k < NP; k++) begin
            cv |= int'(mcoll[k]) << k;
            av |= int'(malive[k]) << k;
        end
        expectEq("collision", int'(collision), cv);
        expectEq("alive", int'(alive), av);
        expectEq("game_over", int'(game_over), int'(mover));
        expectEq("draw", int'(draw), int'(mdraw));
        if (mover && !mdraw) expectEq("winner", int'(winner), mwin);
    endtask

    always @(negedge clk) if (checkEn) checkOutput();

    task automatic applyStimulus(bit r, bit s, bit st, directions d0, directions d1);
        @(negedge clk);
        rst = r; start = s; step = st; dir[0] = d0; dir[1] = d1;
        @(posedge clk);
        #1;
        modelClock(r, s, st, d0, d1);
        rst = 1'b0; start = 1'b0; step = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; dir[0] = WAIT; dir[1] = WAIT;
        applyStimulus(1, 0, 0, WAIT, WAIT);
        checkEn = 1'b1;
        expectEq("reset p0 tile", int'(dmap[5][6]), int'(PLAYER1));
        expectEq("reset p1 tile", int'(dmap[10][6]), int'(PLAYER2));
        expectEq("reset corner", int'(dmap[0][0]), WRAP ? int'(EMPTY) : int'(FRAME));
        expectEq("reset alive", int'(alive), 3);

        // P0 runs right into P1's head
        applyStimulus(0, 1, 0, WAIT, WAIT);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 1, RIGHT, WAIT);
            if (i == 4) begin
                expectEq("A head p0", int'(dmap[9][6]), int'(PLAYER1));
                expectEq("A over early", int'(game_over), 0);
            end
        end
        expectEq("A collision", int'(collision), 1);
        expectEq("A game_over", int'(game_over), 1);
        expectEq("A draw", int'(draw), 0);
        expectEq("A winner", int'(winner), 1);
        applyStimulus(0, 0, 1, RIGHT, RIGHT);
        applyStimulus(0, 0, 1, UP, LEFT);
        applyStimulus(0, 1, 0, WAIT, WAIT);
        expectEq("A rearm tile", int'(dmap[9][6]), int'(EMPTY));
        expectEq("A rearm over", int'(game_over), 0);

        // head-on into each other's heads
        applyStimulus(0, 1, 0, WAIT, WAIT);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 1, RIGHT, LEFT);
            if (i == 2) expectEq("B head p1", int'(dmap[8][6]), int'(PLAYER2));
        end
        expectEq("B collision", int'(collision), 3);
        expectEq("B draw", int'(draw), 1);
        applyStimulus(0, 1, 0, WAIT, WAIT);

        // shared target tile crashes both and stays empty
        applyStimulus(0, 1, 0, WAIT, WAIT);
        applyStimulus(0, 0, 1, RIGHT, WAIT);
        applyStimulus(0, 0, 1, RIGHT, LEFT);
        applyStimulus(0, 0, 1, RIGHT, LEFT);
        expectEq("C shared tile", int'(dmap[8][6]), int'(EMPTY));
        expectEq("C draw", int'(draw), 1);
        expectEq("C collision", int'(collision), 3);

        // upward run to the border; start and step together in IDLE drops the step
        applyStimulus(1, 0, 0, WAIT, WAIT);
        applyStimulus(0, 1, 1, UP, WAIT);
        expectEq("D step dropped", int'(dmap[5][5]), int'(EMPTY));
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 0, 1, UP, WAIT);
`ifdef WRAP_EN
            if (i == 6) expectEq("D wrap top", int'(dmap[5][0]), int'(PLAYER1));
            if (i == 7) expectEq("D wrap bottom", int'(dmap[5][11]), int'(PLAYER1));
`else
            if (i == 5) expectEq("D near frame", int'(dmap[5][1]), int'(PLAYER1));
            if (i == 6) expectEq("D frame crash", int'(collision), 1);
`endif
        end

        // reversal is ignored, then reset together with step wins
        applyStimulus(1, 0, 0, WAIT, WAIT);
        applyStimulus(0, 0, 1, RIGHT, WAIT);
        expectEq("E idle step", int'(dmap[6][6]), int'(EMPTY));
        applyStimulus(0, 1, 0, WAIT, WAIT);
        applyStimulus(0, 0, 1, RIGHT, WAIT);
        applyStimulus(0, 0, 1, LEFT, WAIT);
        expectEq("E no reverse", int'(dmap[6][6]), int'(PLAYER1));
        expectEq("E no collision", int'(collision), 0);
        applyStimulus(1, 0, 1, RIGHT, LEFT);
        expectEq("E rst map", int'(dmap[6][6]), int'(EMPTY));
        expectEq("E rst alive", int'(alive), 3);

        // P1 drives into P0's trail; P0's reverse request is ignored
        applyStimulus(0, 1, 0, WAIT, WAIT);
        applyStimulus(0, 0, 1, DOWN, WAIT);
        applyStimulus(0, 0, 1, DOWN, WAIT);
        applyStimulus(0, 0, 1, UP, LEFT);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, WAIT, LEFT);
        expectEq("F collision", int'(collision), 2);
        expectEq("F winner", int'(winner), 0);
        expectEq("F trail kept", int'(dmap[6][6]), int'(PLAYER2));

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_control_multi.md
GAME_CONTROL_MULTI -- requirements
Module: game_control_multi

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of players, legal 1..4.
REQ-002 SHALL have parameter MAP_W, default MAP_WIDTH, map width in tiles.
REQ-003 SHALL have parameter MAP_H, default MAP_HEIGHT, map height in tiles.
REQ-004 SHALL have parameter COORD_W, default 8, coordinate width in bits; must satisfy 2^COORD_W > max(MAP_W, MAP_H).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-007 SHALL have port start, input, 1, single-cycle pulse that starts or re-arms a game.
REQ-008 SHALL have port step, input, 1, movement tick pulse.
REQ-009 SHALL have port direction, input, directions[N_PLAYERS], requested move per player (WAIT/RIGHT/LEFT/DOWN/UP).
REQ-010 SHALL have port map, output, tile[MAP_W][MAP_H], registered map.
REQ-011 SHALL have port collision, output, N_PLAYERS, sticky per-player crash flag.
REQ-012 SHALL have port alive, output, N_PLAYERS, per-player alive flag.
REQ-013 SHALL have port game_over, output, 1, game finished.
REQ-014 SHALL have port draw, output, 1, game finished with no survivor.
REQ-015 SHALL have port winner, output, 2, survivor index; valid only when game_over=1 and draw=0.

Function
REQ-016 SHALL implement states IDLE, RUN, OVER; IDLE->RUN on start; RUN->OVER on game-end condition; OVER->IDLE on start, with map and players reinitialised on that same edge.
REQ-017 SHALL ignore step outside RUN; if start and step arrive together in IDLE, start is taken and step is dropped.
REQ-018 SHALL place player k at x=(k+1)*MAP_W/(N_PLAYERS+1) (integer division), y=MAP_H/2, writing tile PLAYER1+k; game_pkg enumerates PLAYER1..PLAYER4 consecutively.
REQ-019 SHALL, on a step in RUN, evaluate all alive players in parallel against the pre-step map; map, heads, collision, alive and game_over update on the next rising edge (latency 1).
REQ-020 SHALL treat WAIT, and any direction opposite to the player's last non-WAIT move, as no move: position unchanged, no tile check, no collision.
REQ-021 SHALL crash a moving player whose target tile is not EMPTY (FRAME, any trail or any head); a crashed player keeps its trail, stops moving, and sets collision=1, alive=0.
REQ-022 SHALL crash all moving players that target the same tile on one step, and SHALL leave that tile unchanged.
REQ-023 SHALL write PLAYER1+k to a surviving mover's target tile and update its head coordinates.
REQ-024 SHALL, with N_PLAYERS>1, end the game when at most one player is alive: exactly one alive gives winner=its index, draw=0; none alive gives draw=1.
REQ-025 SHALL, with N_PLAYERS=1, end the game when the player crashes, with draw=1.
REQ-026 SHALL hold map, collision, alive, winner and draw stable in OVER until start or rst.
REQ-027 SHALL compute coordinates in COORD_W-bit unsigned arithmetic; targets outside 0..MAP_W-1 / 0..MAP_H-1 cannot occur without WRAP_EN, because the border is FRAME.

Reset
REQ-028 SHALL, on rst, enter IDLE; initialise the map per REQ-018 and REQ-030/031; set collision=0, alive=all ones, game_over=0, draw=0, winner=0, and last move of every player to none.
REQ-029 SHALL let rst asserted mid-game (any state, same cycle as step or start) win over all other inputs.

Configuration
REQ-030 SHALL, without WRAP_EN, fill tiles with x=0, x=MAP_W-1, y=0 and y=MAP_H-1 with FRAME, all others EMPTY except player heads.
REQ-031 SHALL, with WRAP_EN defined, write no FRAME tiles and wrap targets modulo MAP_W/MAP_H (x=MAP_W-1 RIGHT gives x=0; y=0 UP gives y=MAP_H-1).

Verification (N_PLAYERS=2, MAP_W=16, MAP_H=12 unless stated; starts (5,6) and (10,6))
REQ-032 SHALL cover: start; P0 RIGHT, P1 WAIT, 5 steps -> P0 head (9,6) after 4 steps; step 5 gives collision=01, game_over=1, draw=0, winner=1 one cycle after the step.
REQ-033 SHALL cover: P0 RIGHT, P1 LEFT, 3 steps -> heads (7,6),(8,6) after 2 steps; step 3 crashes both: collision=11, draw=1.
REQ-034 SHALL cover: MAP_W=17 (starts (5,6),(11,6)), P0 RIGHT, P1 LEFT, 3 steps -> step 3 shared target (8,6): both crash, draw=1, map[8][6]=EMPTY.
REQ-035 SHALL cover: P0 UP, P1 WAIT, 6 steps -> without WRAP_EN P0 reaches (5,1) at step 5 and crashes on FRAME at step 6; with WRAP_EN P0 is at (5,0) after step 6 and at (5,11) after step 7, with no collision.
REQ-036 SHALL cover: P0 RIGHT one step, then LEFT one step -> head stays (6,6), no collision; then rst asserted together with step -> IDLE, initial map, all flags cleared.
